arp_tx_arbiter: RTL and testbench
=================================

# arp_tx_arbiter

Frame-atomic arbiter that shares the single ARP transmit byte stream between the ARP response generator and the ARP request generator. Each source raises a request, waits for a grant, then streams one complete frame. The arbiter forwards that frame, registered, to the shared `tx_rr_*` output and never interleaves bytes from two frames. It enforces an inter-frame gap, gives responses priority with a starvation guard for requests, and aborts a granted frame that never terminates.

## Interface
Parameters:
- `IFG`, 12: idle cycles inserted after every frame; 0 is legal.
- `MAX_RES_RUN`, 4: consecutive response frames allowed while a request frame is waiting.
- `TIMEOUT`, 2047: cycles a grant may stay open without EOF; 11-bit counter, range 1–2047.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `res_req` in 1: response source has a frame ready; level.
- `res_gnt` out 1: response source owns the output.
- `rx_res` in 8: response frame data byte.
- `rx_res_en_n` in 1: response byte valid, active-low.
- `rx_res_sof_n` in 1: response start of frame, active-low.
- `rx_res_eof_n` in 1: response end of frame, active-low.
- `req_req`, `req_gnt`, `rx_req`, `rx_req_en_n`, `rx_req_sof_n`, `rx_req_eof_n`: same roles, for the request source.
- `tx_rr` out 8: shared output data byte.
- `tx_rr_en_n` out 1: output byte valid, active-low.
- `tx_rr_sof_n` out 1: output start of frame, active-low.
- `tx_rr_eof_n` out 1: output end of frame, active-low.
- `frame_abort` out 1: one-cycle pulse when a frame is killed by timeout.

## Operation
- States: IDLE, GNT_RES, GNT_REQ, GAP.
- Reset (`rst_n` low, async) values:
  - state = IDLE.
  - `res_gnt` = `req_gnt` = 0.
  - `tx_rr` = 8'h00; `tx_rr_en_n`, `tx_rr_sof_n`, `tx_rr_eof_n` = 1.
  - `frame_abort` = 0.
  - run counter, gap counter and timeout counter = 0.
- Arbitration in IDLE, decided on the current cycle's inputs:
  - If `res_req`=1 and not (run==`MAX_RES_RUN` and `req_req`=1): go to GNT_RES.
  - Else if `req_req`=1: go to GNT_REQ.
  - Else stay in IDLE.
  - If both are requesting, response wins unless the run counter is saturated.
- Run counter:
  - Increments, saturating at `MAX_RES_RUN`, when a response frame completes while `req_req`=1.
  - Clears when GNT_REQ is entered.
  - Clears when GNT_RES is entered with `req_req`=0.
- Grant phase:
  - The `*_gnt` flag is registered. It is high for every cycle the arbiter is in GNT_x and low in every other state.
  - Each cycle, the selected source's byte and flags are copied to `tx_rr_*` one cycle later, only when its `en_n`=0.
  - When the selected source's `en_n`=1, `tx_rr_*` outputs the idle values (8'h00, 1, 1, 1).
  - The non-granted source's inputs are ignored entirely.
  - `*_req` is ignored after grant. A source may drop `req` before grant; it is then not granted.
  - SOF and EOF are passed through unchecked.
- End of frame:
  - The selected source presents `en_n`=0 and `eof_n`=0 → next state is GAP with the gap counter loaded to `IFG`.
  - If `IFG`=0, next state is IDLE instead.
- GAP:
  - Counter decrements once per cycle. At 1, the next state is IDLE. Both grants stay low.
- Timeout:
  - The timeout counter clears on entry to GNT_x and increments every cycle in GNT_x.
  - When it reaches `TIMEOUT` with no EOF seen, the arbiter pulses `frame_abort` and leaves GNT_x, handled the same as an EOF (GAP, or IDLE if `IFG`=0).
  - If at least one byte of the frame was forwarded, the arbiter also drives one terminating beat: `tx_rr`=8'h00, `en_n`=0, `eof_n`=0, `sof_n`=1.
  - If nothing was forwarded, no beat is driven.
  - EOF on the same cycle as the timeout is treated as a normal EOF, with no abort.

## Timing
- Request to grant: `*_req` high in IDLE at cycle N → `*_gnt`=1 at N+1.
- Source to output: one-cycle pipeline delay from source byte to `tx_rr_*`.
- Release: EOF accepted at cycle E → `*_gnt`=0 at E+1 and `tx_rr_eof_n`=0 at E+1.
- Next grant: the earliest next grant is at E+2+`IFG`.
- Abort: `frame_abort` and the terminating beat appear in the cycle after the timeout count is reached.

## Test plan
- Single response frame: `res_req`, 42-byte frame → `res_gnt` at N+1; 42 output beats with 1-cycle delay, SOF on beat 1, EOF on beat 42; `res_gnt` low next cycle.
- Both requesting in IDLE with IFG=12 → response is granted first; the request is granted exactly 14 cycles after the response EOF cycle.
- `res_req` held continuously with `req_req` pending, MAX_RES_RUN=4 → response frames 1–4 are granted, then the request frame, then responses again.
- Granted request source sends SOF plus 5 bytes then stalls, TIMEOUT=20 → `frame_abort` pulses 21 cycles after grant; terminating beat 8'h00 with EOF; next arbitration proceeds normally.
- Non-granted source toggles `en_n` during another frame → no corruption; output equals the granted frame byte-for-byte.
- `rst_n` asserted mid-frame → all outputs take their reset values immediately, asynchronously; after release the arbiter is in IDLE and regrants on the next request.

Source files
------------

// File: rtl/arp_tx_arbiter.sv
// Frame-atomic arbiter sharing the ARP transmit byte stream between the response
// and request generators, with inter-frame gap, starvation guard and frame timeout.
module arp_tx_arbiter #(
  parameter int IFG         = 12,
  parameter int MAX_RES_RUN = 4,
  parameter int TIMEOUT     = 2047
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       res_req,
  output logic       res_gnt,
  input  logic [7:0] rx_res,
  input  logic       rx_res_en_n,
  input  logic       rx_res_sof_n,
  input  logic       rx_res_eof_n,
  input  logic       req_req,
  output logic       req_gnt,
  input  logic [7:0] rx_req,
  input  logic       rx_req_en_n,
  input  logic       rx_req_sof_n,
  input  logic       rx_req_eof_n,
  output logic [7:0] tx_rr,
  output logic       tx_rr_en_n,
  output logic       tx_rr_sof_n,
  output logic       tx_rr_eof_n,
  output logic       frame_abort
);

  typedef enum logic [1:0] {IDLE, GNT_RES, GNT_REQ, GAP} state_t;

  localparam logic [7:0]  RUN_MAX   = 8'(MAX_RES_RUN);
  localparam logic [15:0] IFG_V     = 16'(IFG);
  localparam logic [10:0] TIMEOUT_V = 11'(TIMEOUT);

  state_t      state_r, state_s;
  logic [7:0]  run_r;
  logic [15:0] gap_r;
  logic [10:0] tcnt_r;
  logic        sent_r;
  logic        res_gnt_r, req_gnt_r;
  logic [7:0]  tx_rr_r;
  logic        tx_en_n_r, tx_sof_n_r, tx_eof_n_r, abort_r;

  logic [7:0]  sel_data_s;
  logic        sel_en_n_s, sel_sof_n_s, sel_eof_n_s;
  logic        in_gnt_s, eof_s, timeout_s, done_s;

  // Select the granted source's byte stream; anything else looks idle.
  always_comb begin
    sel_data_s  = 8'h00;
    sel_en_n_s  = 1'b1;
    sel_sof_n_s = 1'b1;
    sel_eof_n_s = 1'b1;
    case (state_r)
      GNT_RES: begin
        sel_data_s  = rx_res;
        sel_en_n_s  = rx_res_en_n;
        sel_sof_n_s = rx_res_sof_n;
        sel_eof_n_s = rx_res_eof_n;
      end
      GNT_REQ: begin
        sel_data_s  = rx_req;
        sel_en_n_s  = rx_req_en_n;
        sel_sof_n_s = rx_req_sof_n;
        sel_eof_n_s = rx_req_eof_n;
      end
      default: begin
        sel_data_s  = 8'h00;
        sel_en_n_s  = 1'b1;
        sel_sof_n_s = 1'b1;
        sel_eof_n_s = 1'b1;
      end
    endcase
  end

  // An EOF landing on the timeout cycle wins, so that frame ends cleanly.
  assign in_gnt_s  = (state_r == GNT_RES) || (state_r == GNT_REQ);
  assign eof_s     = in_gnt_s && !sel_en_n_s && !sel_eof_n_s;
  assign timeout_s = in_gnt_s && (tcnt_r == TIMEOUT_V) && !eof_s;
  assign done_s    = eof_s || timeout_s;

  // Next-state arbitration with response priority and run-length guard.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (res_req && !((run_r == RUN_MAX) && req_req)) begin
          state_s = GNT_RES;
        end else if (req_req) begin
          state_s = GNT_REQ;
        end else begin
          state_s = IDLE;
        end
      end
      GNT_RES, GNT_REQ: begin
        if (done_s) begin
          state_s = (IFG_V == 16'd0) ? IDLE : GAP;
        end else begin
          state_s = state_r;
        end
      end
      GAP: begin
        if (gap_r <= 16'd1) begin
          state_s = IDLE;
        end else begin
          state_s = GAP;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State and registered grant flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      res_gnt_r <= 1'b0;
      req_gnt_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      res_gnt_r <= (state_s == GNT_RES);
      req_gnt_r <= (state_s == GNT_REQ);
    end
  end

  // Gap, timeout and forwarded-byte tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_r  <= 16'd0;
      tcnt_r <= 11'd0;
      sent_r <= 1'b0;
    end else begin
      if (in_gnt_s && done_s) begin
        gap_r <= IFG_V;
      end else if (state_r == GAP) begin
        gap_r <= gap_r - 16'd1;
      end else begin
        gap_r <= gap_r;
      end
      if (in_gnt_s && !done_s) begin
        tcnt_r <= tcnt_r + 11'd1;
        sent_r <= sent_r || !sel_en_n_s;
      end else begin
        tcnt_r <= 11'd0;
        sent_r <= 1'b0;
      end
    end
  end

  // Consecutive-response run counter used as a starvation guard.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_r <= 8'd0;
    end else if ((state_r == IDLE) && (state_s == GNT_REQ)) begin
      run_r <= 8'd0;
    end else if ((state_r == IDLE) && (state_s == GNT_RES) && !req_req) begin
      run_r <= 8'd0;
    end else if ((state_r == GNT_RES) && done_s && req_req && (run_r < RUN_MAX)) begin
      run_r <= run_r + 8'd1;
    end else begin
      run_r <= run_r;
    end
  end

  // Output pipeline stage; a timed-out frame that already started gets a closing beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_rr_r    <= 8'h00;
      tx_en_n_r  <= 1'b1;
      tx_sof_n_r <= 1'b1;
      tx_eof_n_r <= 1'b1;
      abort_r    <= 1'b0;
    end else if (timeout_s) begin
      abort_r <= 1'b1;
      if (sent_r || !sel_en_n_s) begin
        tx_rr_r    <= 8'h00;
        tx_en_n_r  <= 1'b0;
        tx_sof_n_r <= 1'b1;
        tx_eof_n_r <= 1'b0;
      end else begin
        tx_rr_r    <= 8'h00;
        tx_en_n_r  <= 1'b1;
        tx_sof_n_r <= 1'b1;
        tx_eof_n_r <= 1'b1;
      end
    end else begin
      abort_r <= 1'b0;
      if (!sel_en_n_s) begin
        tx_rr_r    <= sel_data_s;
        tx_en_n_r  <= 1'b0;
        tx_sof_n_r <= sel_sof_n_s;
        tx_eof_n_r <= sel_eof_n_s;
      end else begin
        tx_rr_r    <= 8'h00;
        tx_en_n_r  <= 1'b1;
        tx_sof_n_r <= 1'b1;
        tx_eof_n_r <= 1'b1;
      end
    end
  end

  assign res_gnt     = res_gnt_r;
  assign req_gnt     = req_gnt_r;
  assign tx_rr       = tx_rr_r;
  assign tx_rr_en_n  = tx_en_n_r;
  assign tx_rr_sof_n = tx_sof_n_r;
  assign tx_rr_eof_n = tx_eof_n_r;
  assign frame_abort = abort_r;

endmodule

// File: tb/tb_arp_tx_arbiter.sv
// Directed bench for arp_tx_arbiter: dut_a (long timeout) covers arbitration and
// framing, dut_t (TIMEOUT=20) shares the stimulus and covers the abort paths.
module tb_arp_tx_arbiter;
  logic       clk, rst_n;
  logic       res_req, req_req;
  logic [7:0] rx_res, rx_req;
  logic       rx_res_en_n, rx_res_sof_n, rx_res_eof_n;
  logic       rx_req_en_n, rx_req_sof_n, rx_req_eof_n;

  logic       a_res_gnt, a_req_gnt, a_en_n, a_sof_n, a_eof_n, a_abort;
  logic       t_res_gnt, t_req_gnt, t_en_n, t_sof_n, t_eof_n, t_abort;
  logic [7:0] a_tx, t_tx;

  logic       which_dut;
  logic       o_res_gnt, o_req_gnt, o_en_n, o_sof_n, o_eof_n, o_abort;
  logic [7:0] o_tx;

  int checks, errors;
  int cnt;
  bit who;

  arp_tx_arbiter #(.IFG(12), .MAX_RES_RUN(4), .TIMEOUT(2047)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .res_req(res_req), .res_gnt(a_res_gnt), .rx_res(rx_res),
    .rx_res_en_n(rx_res_en_n), .rx_res_sof_n(rx_res_sof_n), .rx_res_eof_n(rx_res_eof_n),
    .req_req(req_req), .req_gnt(a_req_gnt), .rx_req(rx_req),
    .rx_req_en_n(rx_req_en_n), .rx_req_sof_n(rx_req_sof_n), .rx_req_eof_n(rx_req_eof_n),
    .tx_rr(a_tx), .tx_rr_en_n(a_en_n), .tx_rr_sof_n(a_sof_n), .tx_rr_eof_n(a_eof_n),
    .frame_abort(a_abort)
  );

  arp_tx_arbiter #(.IFG(12), .MAX_RES_RUN(4), .TIMEOUT(20)) dut_t (
    .clk(clk), .rst_n(rst_n),
    .res_req(res_req), .res_gnt(t_res_gnt), .rx_res(rx_res),
    .rx_res_en_n(rx_res_en_n), .rx_res_sof_n(rx_res_sof_n), .rx_res_eof_n(rx_res_eof_n),
    .req_req(req_req), .req_gnt(t_req_gnt), .rx_req(rx_req),
    .rx_req_en_n(rx_req_en_n), .rx_req_sof_n(rx_req_sof_n), .rx_req_eof_n(rx_req_eof_n),
    .tx_rr(t_tx), .tx_rr_en_n(t_en_n), .tx_rr_sof_n(t_sof_n), .tx_rr_eof_n(t_eof_n),
    .frame_abort(t_abort)
  );

  assign o_res_gnt = which_dut ? t_res_gnt : a_res_gnt;
  assign o_req_gnt = which_dut ? t_req_gnt : a_req_gnt;
  assign o_tx      = which_dut ? t_tx      : a_tx;
  assign o_en_n    = which_dut ? t_en_n    : a_en_n;
  assign o_sof_n   = which_dut ? t_sof_n   : a_sof_n;
  assign o_eof_n   = which_dut ? t_eof_n   : a_eof_n;
  assign o_abort   = which_dut ? t_abort   : a_abort;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] beat(input logic en_n, input logic sof_n, input logic eof_n,
                                       input logic [7:0] d);
    return {21'd0, en_n, sof_n, eof_n, d};
  endfunction

  function automatic logic [31:0] obs_beat();
    return {21'd0, o_en_n, o_sof_n, o_eof_n, o_tx};
  endfunction

  task automatic drive_src(input bit src, input logic en_n, input logic sof_n,
                           input logic eof_n, input logic [7:0] d);
    if (src) begin
      rx_req = d; rx_req_en_n = en_n; rx_req_sof_n = sof_n; rx_req_eof_n = eof_n;
    end else begin
      rx_res = d; rx_res_en_n = en_n; rx_res_sof_n = sof_n; rx_res_eof_n = eof_n;
    end
  endtask

  // Called at the negedge where the grant is first seen; the idle source is fed noise.
  task automatic stream(input bit src, input int len, input logic [7:0] base);
    logic [7:0] b;
    for (int i = 0; i <= len; i++) begin
      if (i > 0) begin
        @(negedge clk);
        b = base + 8'(i - 1);
        chk("beat", obs_beat(), beat(1'b0, (i == 1) ? 1'b0 : 1'b1, (i == len) ? 1'b0 : 1'b1, b));
        chk("gnt_hold", 32'(src ? o_req_gnt : o_res_gnt), 32'(i < len));
        chk("no_abort", 32'(o_abort), 32'd0);
      end
      if (i < len) begin
        b = base + 8'(i);
        drive_src(src, 1'b0, (i == 0) ? 1'b0 : 1'b1, (i == len - 1) ? 1'b0 : 1'b1, b);
        drive_src(!src, 1'(i % 2), 1'b0, 1'b0, ~b);
      end else begin
        drive_src(src, 1'b1, 1'b1, 1'b1, 8'h00);
        drive_src(!src, 1'b1, 1'b1, 1'b1, 8'h00);
      end
    end
  endtask

  task automatic wait_gnt(output int n, output bit w);
    n = 0;
    while (!o_res_gnt && !o_req_gnt && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("gnt_wait", 32'(o_res_gnt | o_req_gnt), 32'd1);
    w = o_req_gnt;
  endtask

  initial begin
    checks = 0; errors = 0; which_dut = 1'b0;
    rst_n = 1'b0; res_req = 1'b0; req_req = 1'b0;
    drive_src(1'b0, 1'b1, 1'b1, 1'b1, 8'h00);
    drive_src(1'b1, 1'b1, 1'b1, 1'b1, 8'h00);
    repeat (2) @(negedge clk);
    chk("rst_res_gnt", 32'(o_res_gnt), 32'd0);
    chk("rst_req_gnt", 32'(o_req_gnt), 32'd0);
    chk("rst_beat", obs_beat(), beat(1'b1, 1'b1, 1'b1, 8'h00));
    chk("rst_abort", 32'(o_abort), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single 42-byte response frame.
    res_req = 1'b1;
    wait_gnt(cnt, who);
    chk("t1_latency", 32'(cnt), 32'd1);
    chk("t1_who", 32'(who), 32'd0);
    res_req = 1'b0;
    stream(1'b0, 42, 8'h10);

    // Both requesting: response first, request 14 cycles after its EOF.
    res_req = 1'b1; req_req = 1'b1;
    wait_gnt(cnt, who);
    chk("t2_res_gap", 32'(cnt), 32'd13);
    chk("t2_res_who", 32'(who), 32'd0);
    res_req = 1'b0;
    stream(1'b0, 3, 8'h40);
    wait_gnt(cnt, who);
    chk("t2_req_gap", 32'(cnt), 32'd13);
    chk("t2_req_who", 32'(who), 32'd1);
    req_req = 1'b0;
    stream(1'b1, 4, 8'h60);

    // Starvation guard: four responses, then the waiting request, then responses.
    res_req = 1'b1; req_req = 1'b1;
    for (int f = 0; f < 6; f++) begin
      wait_gnt(cnt, who);
      chk("t3_gap", 32'(cnt), 32'd13);
      chk("t3_order", 32'(who), 32'(f == 4));
      if (who) req_req = 1'b0;
      if (f == 5) res_req = 1'b0;
      stream(who, 2, 8'h80 + 8'(4 * f));
    end

    // Asynchronous reset in the middle of a frame.
    res_req = 1'b1;
    wait_gnt(cnt, who);
    res_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_src(1'b0, 1'b0, (i == 0) ? 1'b0 : 1'b1, 1'b1, 8'hA0 + 8'(i));
      @(negedge clk);
    end
    chk("t6_pre_gnt", 32'(o_res_gnt), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_gnt", 32'(o_res_gnt), 32'd0);
    chk("t6_rst_beat", obs_beat(), beat(1'b1, 1'b1, 1'b1, 8'h00));
    chk("t6_rst_abort", 32'(o_abort), 32'd0);
    drive_src(1'b0, 1'b1, 1'b1, 1'b1, 8'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    req_req = 1'b1;
    wait_gnt(cnt, who);
    chk("t6_regrant", 32'(cnt), 32'd1);
    chk("t6_who", 32'(who), 32'd1);
    req_req = 1'b0;
    stream(1'b1, 3, 8'hC0);

    // Timeout after SOF plus 5 bytes: abort 21 cycles after grant, with closing beat.
    which_dut = 1'b1;
    req_req = 1'b1;
    wait_gnt(cnt, who);
    chk("t4_gap", 32'(cnt), 32'd13);
    req_req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive_src(1'b1, 1'b0, (i == 0) ? 1'b0 : 1'b1, 1'b1, 8'hD0 + 8'(i));
      @(negedge clk);
      chk("t4_beat", obs_beat(), beat(1'b0, (i == 0) ? 1'b0 : 1'b1, 1'b1, 8'hD0 + 8'(i)));
    end
    drive_src(1'b1, 1'b1, 1'b1, 1'b1, 8'h00);
    for (int k = 7; k <= 21; k++) begin
      @(negedge clk);
      if (k < 21) begin
        chk("t4_no_abort", 32'(o_abort), 32'd0);
      end else begin
        chk("t4_abort", 32'(o_abort), 32'd1);
        chk("t4_term_beat", obs_beat(), beat(1'b0, 1'b1, 1'b0, 8'h00));
        chk("t4_gnt_drop", 32'(o_req_gnt), 32'd0);
      end
    end
    @(negedge clk);
    chk("t4_abort_pulse", 32'(o_abort), 32'd0);
    chk("t4_idle_beat", obs_beat(), beat(1'b1, 1'b1, 1'b1, 8'h00));

    // Timeout with nothing forwarded: abort but no beat.
    res_req = 1'b1;
    wait_gnt(cnt, who);
    chk("t4b_gap", 32'(cnt), 32'd12);
    chk("t4b_who", 32'(who), 32'd0);
    res_req = 1'b0;
    for (int k = 1; k <= 21; k++) begin
      @(negedge clk);
      if (k == 20) begin
        chk("t4b_no_abort", 32'(o_abort), 32'd0);
        chk("t4b_gnt", 32'(o_res_gnt), 32'd1);
      end else if (k == 21) begin
        chk("t4b_abort", 32'(o_abort), 32'd1);
        chk("t4b_no_beat", obs_beat(), beat(1'b1, 1'b1, 1'b1, 8'h00));
        chk("t4b_gnt_drop", 32'(o_res_gnt), 32'd0);
      end
    end

    // EOF on the timeout cycle is a normal end of frame.
    req_req = 1'b1;
    wait_gnt(cnt, who);
    chk("t4c_gap", 32'(cnt), 32'd13);
    chk("t4c_who", 32'(who), 32'd1);
    req_req = 1'b0;
    stream(1'b1, 21, 8'hE0);
    @(negedge clk);
    chk("t4c_no_abort", 32'(o_abort), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
